// File: rtl/reg_write_arbiter.sv
// Register-bank write master: merges unstallable ALU results with FIFO-buffered
// load results into at most one bank write per cycle, with a per-register busy scoreboard.
module reg_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  input  logic [ADDR_W-1:0]    alu_rd,
  input  logic [DATA_W-1:0]    alu_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [ADDR_W-1:0]    ld_rd,
  input  logic [DATA_W-1:0]    ld_data,
  input  logic                 issue_valid,
  input  logic [ADDR_W-1:0]    issue_rd,
  output logic [2**ADDR_W-1:0] busy,
  output logic [ADDR_W-1:0]    ld_count,
  output logic                 RegEn,
  output logic [ADDR_W-1:0]    WriteRegister,
  output logic [DATA_W-1:0]    WriteData
);
  localparam int PW   = $clog2(DEPTH);
  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] FULL = ADDR_W'(DEPTH);

  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [ADDR_W-1:0] r_mem_rd   [DEPTH];
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [ADDR_W-1:0] r_count;
  logic [NREG-1:0]   r_busy;
  logic              r_regen;
  logic [ADDR_W-1:0] r_wreg;
  logic [DATA_W-1:0] r_wdata;

  logic              w_empty, w_push, w_pop, w_win;
  logic [ADDR_W-1:0] w_win_rd;
  logic [DATA_W-1:0] w_win_data;
  logic [NREG-1:0]   w_busy_nxt;

  // Readiness looks only at the registered count: a full FIFO refuses even while popping.
  assign ld_ready = (r_count != FULL);
  assign w_empty  = (r_count == '0);
  assign w_push   = ld_valid && ld_ready;

  always_comb begin
    w_win      = alu_valid || !w_empty;
    w_pop      = !alu_valid && !w_empty;
    w_win_rd   = alu_valid ? alu_rd   : r_mem_rd[r_rptr];
    w_win_data = alu_valid ? alu_data : r_mem_data[r_rptr];
  end

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_win)       w_busy_nxt[w_win_rd] = 1'b0;
    if (issue_valid) w_busy_nxt[issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wptr] <= ld_data;
      r_mem_rd[r_wptr]   <= ld_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_busy  <= '0;
      r_regen <= 1'b0;
      r_wreg  <= '0;
      r_wdata <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_busy <= w_busy_nxt;
      // Writes to register 0 still consume the winner slot but never strobe the bank.
      if (w_win) begin
        r_regen <= (w_win_rd != '0);
        r_wreg  <= w_win_rd;
        r_wdata <= w_win_data;
      end else begin
        r_regen <= 1'b0;
      end
    end
  end

  assign busy          = r_busy;
  assign ld_count      = r_count;
  assign RegEn         = r_regen;
  assign WriteRegister = r_wreg;
  assign WriteData     = r_wdata;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: reset, ALU path, contention, r0 drop,
// scoreboard set-wins, and FIFO pointer wrap.
module tb_reg_write_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 alu_valid;
  logic [ADDR_W-1:0]    alu_rd;
  logic [DATA_W-1:0]    alu_data;
  logic                 ld_valid;
  logic                 ld_ready;
  logic [ADDR_W-1:0]    ld_rd;
  logic [DATA_W-1:0]    ld_data;
  logic                 issue_valid;
  logic [ADDR_W-1:0]    issue_rd;
  logic [2**ADDR_W-1:0] busy;
  logic [ADDR_W-1:0]    ld_count;
  logic                 RegEn;
  logic [ADDR_W-1:0]    WriteRegister;
  logic [DATA_W-1:0]    WriteData;

  int n_checks = 0;
  int n_fail   = 0;

  reg_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .busy(busy), .ld_count(ld_count),
    .RegEn(RegEn), .WriteRegister(WriteRegister), .WriteData(WriteData)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    ld_valid = 0; ld_rd = '0; ld_data = '0;
    issue_valid = 0; issue_rd = '0;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    tick(); tick();
    n_checks++; if (RegEn !== 1'b0) begin n_fail++; $display("FAIL reset_regen: got %b expected 0", RegEn); end
    n_checks++; if (WriteRegister !== '0) begin n_fail++; $display("FAIL reset_wreg: got %0d expected 0", WriteRegister); end
    n_checks++; if (WriteData !== '0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", WriteData); end
    n_checks++; if (busy !== '0) begin n_fail++; $display("FAIL reset_busy: got %h expected 0", busy); end
    n_checks++; if (ld_count !== '0 || ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_fifo: got count %0d ready %b expected 0/1", ld_count, ld_ready); end
    rst = 0;
    tick();
    // Fill FIFO with 3 loads while ALU holds the port, and reserve r7.
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h1;
    issue_valid = 1; issue_rd = 5'd7;
    ld_valid = 1;
    for (int i = 0; i < 3; i++) begin
      ld_rd = ADDR_W'(i + 1); ld_data = 32'h1000_0000 + i;
      tick();
    end
    n_checks++; if (ld_count !== 5'd3) begin n_fail++; $display("FAIL midstream_count: got %0d expected 3", ld_count); end
    n_checks++; if (busy !== 32'h0000_0080) begin n_fail++; $display("FAIL midstream_busy: got %h expected 00000080", busy); end
    idle();
    #2 rst = 1;
    #1;
    n_checks++; if (RegEn !== 1'b0) begin n_fail++; $display("FAIL async_regen: got %b expected 0", RegEn); end
    n_checks++; if (busy !== '0) begin n_fail++; $display("FAIL async_busy: got %h expected 0", busy); end
    n_checks++; if (ld_count !== '0 || ld_ready !== 1'b1) begin n_fail++; $display("FAIL async_fifo: got count %0d ready %b expected 0/1", ld_count, ld_ready); end
    tick();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (RegEn !== 1'b0 || ld_count !== '0) begin n_fail++; $display("FAIL stale_write%0d: got regen %b count %0d expected 0/0", i, RegEn, ld_count); end
    end
  endtask

  task automatic test_alu_path();
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    idle();
    n_checks++; if (RegEn !== 1'b1 || WriteRegister !== 5'd5 || WriteData !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL alu_write: got en %b rd %0d data %h expected 1/5/deadbeef", RegEn, WriteRegister, WriteData); end
    tick();
    n_checks++; if (RegEn !== 1'b0 || WriteRegister !== 5'd5 || WriteData !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL alu_idle_hold: got en %b rd %0d data %h expected 0/5/deadbeef", RegEn, WriteRegister, WriteData); end
  endtask

  task automatic test_contention();
    logic [5:0] exp_ready;
    logic [4:0] exp_cnt_drain [5];
    int idx;
    exp_ready = 6'b001111;   // bit k = ld_ready before edge k
    exp_cnt_drain = '{5'd3, 5'd3, 5'd2, 5'd1, 5'd0};
    idx = 1;
    for (int k = 0; k < 6; k++) begin
      alu_valid = 1; alu_rd = ADDR_W'(10 + k); alu_data = 32'hA1A0_0000 + k;
      ld_valid = 1; ld_rd = ADDR_W'(idx); ld_data = 32'h1000_0000 + idx;
      n_checks++; if (ld_ready !== exp_ready[k]) begin n_fail++; $display("FAIL cont_ready%0d: got %b expected %b", k, ld_ready, exp_ready[k]); end
      if (exp_ready[k]) idx++;
      tick();
      n_checks++; if (RegEn !== 1'b1 || WriteRegister !== ADDR_W'(10 + k) || ld_count !== ((k < 3) ? ADDR_W'(k + 1) : 5'd4)) begin
        n_fail++; $display("FAIL cont_alu%0d: got en %b rd %0d count %0d expected 1/%0d/%0d", k, RegEn, WriteRegister, ld_count, 10 + k, (k < 3) ? k + 1 : 4); end
    end
    alu_valid = 0;
    // Load 5 is still offered; FIFO is full at the first drain edge so it must wait.
    for (int k = 0; k < 5; k++) begin
      ld_valid = (k < 2); ld_rd = 5'd5; ld_data = 32'h1000_0005;
      n_checks++; if (ld_ready !== (k != 0)) begin n_fail++; $display("FAIL drain_ready%0d: got %b expected %b", k, ld_ready, k != 0); end
      tick();
      n_checks++; if (RegEn !== 1'b1 || WriteRegister !== ADDR_W'(k + 1) || WriteData !== 32'h1000_0000 + k + 1 || ld_count !== exp_cnt_drain[k]) begin
        n_fail++; $display("FAIL drain_write%0d: got en %b rd %0d data %h count %0d expected 1/%0d/%h/%0d",
          k, RegEn, WriteRegister, WriteData, ld_count, k + 1, 32'h1000_0000 + k + 1, exp_cnt_drain[k]); end
    end
    idle();
    tick();
    n_checks++; if (RegEn !== 1'b0) begin n_fail++; $display("FAIL cont_quiet: got %b expected 0", RegEn); end
  endtask

  task automatic test_r0_drop();
    alu_valid = 1; alu_rd = '0; alu_data = 32'd7;
    tick();
    idle();
    n_checks++; if (RegEn !== 1'b0) begin n_fail++; $display("FAIL r0_alu: got %b expected 0", RegEn); end
    ld_valid = 1; ld_rd = '0; ld_data = 32'h55;
    tick();
    idle();
    n_checks++; if (RegEn !== 1'b0 || ld_count !== 5'd1) begin n_fail++; $display("FAIL r0_push: got en %b count %0d expected 0/1", RegEn, ld_count); end
    tick();
    n_checks++; if (RegEn !== 1'b0 || ld_count !== 5'd0) begin n_fail++; $display("FAIL r0_pop: got en %b count %0d expected 0/0", RegEn, ld_count); end
  endtask

  task automatic test_scoreboard();
    issue_valid = 1; issue_rd = 5'd9;
    tick();
    idle();
    n_checks++; if (busy !== 32'h0000_0200) begin n_fail++; $display("FAIL sb_issue: got %h expected 00000200", busy); end
    ld_valid = 1; ld_rd = 5'd9; ld_data = 32'hCAFE_0009;
    tick();
    idle();
    n_checks++; if (busy !== 32'h0000_0200 || RegEn !== 1'b0) begin n_fail++; $display("FAIL sb_pushed: got busy %h en %b expected 00000200/0", busy, RegEn); end
    issue_valid = 1; issue_rd = 5'd9;
    tick();
    idle();
    n_checks++; if (busy !== 32'h0000_0200 || RegEn !== 1'b1 || WriteRegister !== 5'd9 || WriteData !== 32'hCAFE_0009) begin
      n_fail++; $display("FAIL sb_set_wins: got busy %h en %b rd %0d data %h expected 00000200/1/9/cafe0009", busy, RegEn, WriteRegister, WriteData); end
    alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h99;
    issue_valid = 1; issue_rd = '0;
    tick();
    idle();
    n_checks++; if (busy !== '0) begin n_fail++; $display("FAIL sb_clear: got %h expected 0", busy); end
  endtask

  task automatic test_wrap();
    for (int e = 0; e <= 10; e++) begin
      ld_valid = (e < 10); ld_rd = ADDR_W'(e + 1); ld_data = 32'hA000_0000 + e;
      tick();
      n_checks++; if (ld_count !== ((e < 10) ? 5'd1 : 5'd0)) begin n_fail++; $display("FAIL wrap_count%0d: got %0d expected %0d", e, ld_count, (e < 10) ? 1 : 0); end
      if (e >= 1) begin
        n_checks++; if (RegEn !== 1'b1 || WriteRegister !== ADDR_W'(e) || WriteData !== 32'hA000_0000 + e - 1) begin
          n_fail++; $display("FAIL wrap_order%0d: got en %b rd %0d data %h expected 1/%0d/%h", e, RegEn, WriteRegister, WriteData, e, 32'hA000_0000 + e - 1); end
      end
    end
    idle();
    tick();
    n_checks++; if (RegEn !== 1'b0 || ld_count !== '0) begin n_fail++; $display("FAIL wrap_end: got en %b count %0d expected 0/0", RegEn, ld_count); end
  endtask

  initial begin
    test_reset();
    test_alu_path();
    test_contention();
    test_r0_drop();
    test_scoreboard();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
